snes_poll_sequencer: RTL
========================

// Module: snes_poll_sequencer
// PURPOSE
//  Sequences one serial game-controller read: latch pulse on contWrite, NUM_BITS-1 clock pulses on contCLK,
//  samples contRead once per bit, publishes a pressed-high button word. Replaces the free-running clock
//  divider; timing comes from an internal half-period tick. Sits between the controller pins and the APB register file.
// PARAMETERS
//  HALF_DIV    600   PCLK cycles per half-period tick (6 us at 100 MHz); legal >= 2
//  NUM_BITS    16    bits read per poll (bit0 = first bit after latch)
//  POLL_TICKS  2778  ticks between automatic polls (~16.7 ms); used only with SNES_AUTOPOLL_EN
// PORTS
//  PCLK        in   1         system clock
//  PRESET      in   1         asynchronous reset, active-high
//  poll_start  in   1         1-cycle request for a poll; ignored while busy
//  contRead    in   1         controller serial data, active-low (0 = pressed), asynchronous
//  contWrite   out  1         latch to controller, active-high
//  contCLK     out  1         controller clock, idles high
//  buttons     out  NUM_BITS  last completed poll, 1 = pressed, bit i = i-th serial bit
//  data_valid  out  1         1-cycle pulse when buttons updates
//  busy        out  1         high from poll accept until the data_valid cycle inclusive
// BEHAVIOUR
//  Reset: contWrite=0, contCLK=1, buttons=0, data_valid=0, busy=0, state=IDLE, tick counter=0, shift reg=all 1.
//  contRead passes a 2-flop synchroniser before use; sampling uses the synchronised value.
//  Tick: counter 0..HALF_DIV-1, tick=1 when counter==HALF_DIV-1; counter cleared on leaving IDLE.
//  FSM (each non-IDLE state lasts whole ticks; transitions on the tick cycle):
//   IDLE   : contCLK=1, contWrite=0. poll_start (or auto trigger) -> LATCH next cycle, busy=1.
//   LATCH  : contWrite=1 for 2 ticks -> GAP.
//   GAP    : contWrite=0 for 1 tick; on its final tick sample bit0 -> CLK_LO (NUM_BITS>1) else DONE.
//   CLK_LO : contCLK=0 for 1 tick -> CLK_HI.
//   CLK_HI : contCLK=1 for 1 tick; on final tick sample next bit; after bit NUM_BITS-1 -> DONE, else CLK_LO.
//   DONE   : 1 cycle: buttons <= ~shift, data_valid=1, busy=1 -> IDLE (busy=0 next cycle).
//  Poll length: (3 + 2*(NUM_BITS-1))*HALF_DIV + 2 PCLK cycles from poll_start to data_valid (33 ticks at 16 bits).
//  Sampled bit i stored at shift[i]; bit counter width $clog2(NUM_BITS); no wrap beyond NUM_BITS-1.
//  poll_start while busy (including DONE cycle): dropped, no queueing.
//  PRESET mid-poll: immediate return to reset values; partial shift data discarded, buttons=0.
//  Unplugged controller (contRead pulled high) yields buttons=0; not flagged as error.
// CONFIGURATION
//  SNES_AUTOPOLL_EN defined: internal tick-based timer; poll triggered every POLL_TICKS ticks (timer runs
//   in all states, counts from reset, wraps to 0); trigger coincident with busy is dropped; poll_start ORed in.
//  Undefined: no timer logic; polls only on poll_start; POLL_TICKS unused.
// STRUCTURE
//  Package snes_pkg: state encoding (IDLE, LATCH, GAP, CLK_LO, CLK_HI, DONE), LATCH_TICKS=2, GAP_TICKS=1,
//   button index constants (B=0, Y=1, SELECT=2, START=3, UP=4, DOWN=5, LEFT=6, RIGHT=7, A=8, X=9, L=10, R=11).
//  Sub-module ctrl_tick_gen(PCLK, PRESET, clr, tick) parameterised by HALF_DIV; FSM, shift reg, sync in top.
// TESTING (HALF_DIV=4, NUM_BITS=16 unless noted; controller model shifts on contCLK rising, loads on latch fall)
//  1 Reset: assert PRESET -> contCLK=1, contWrite=0, buttons=0, busy=0, data_valid=0 immediately (async).
//  2 Model pattern 16'hFFFE (B pressed), poll_start -> contWrite high 8 cycles, 15 contCLK low pulses of
//    4 cycles, data_valid at cycle 134 after poll_start, buttons=16'h0001.
//  3 Model 16'h5A5A -> buttons=16'hA5A5; second poll with 16'hFFFF -> buttons=16'h0000, one data_valid each.
//  4 poll_start every cycle during a poll -> exactly one data_valid per completed poll, no extra latch.
//  5 PRESET asserted during CLK_HI of bit 7 -> outputs return to reset values; next poll returns correct word.
//  6 SNES_AUTOPOLL_EN, POLL_TICKS=40, no poll_start -> data_valid every 160 cycles, latch period 160 cycles.

Source files
------------

// File: rtl/snes_poll_sequencer_pkg.sv
// Shared definitions for the controller poll sequencer: FSM encoding,
// per-state tick counts and button bit positions within the published word.
package snes_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LATCH  = 3'd1,
        GAP    = 3'd2,
        CLK_LO = 3'd3,
        CLK_HI = 3'd4,
        DONE   = 3'd5
    } state_e;

    localparam int LATCH_TICKS = 2;
    localparam int GAP_TICKS   = 1;

    localparam int BTN_B      = 0;
    localparam int BTN_Y      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;
    localparam int BTN_A      = 8;
    localparam int BTN_X      = 9;
    localparam int BTN_L      = 10;
    localparam int BTN_R      = 11;

endpackage

// File: rtl/snes_poll_sequencer_tick_gen.sv
// Half-period tick generator: one-cycle pulse every HALF_DIV clocks,
// held at phase zero while clr is high.
module ctrl_tick_gen #(
    parameter int HALF_DIV = 600
) (
    input  logic PCLK,
    input  logic PRESET,
    input  logic clr,
    output logic tick
);
    localparam int CW = $clog2(HALF_DIV);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == CW'(HALF_DIV - 1));

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr || tick) cnt_d = '0;
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/snes_poll_sequencer.sv
// Serial game-controller poll sequencer: latch, clock pulses, per-bit sampling, button word.
// Defining SNES_AUTOPOLL_EN adds a free-running timer that triggers a poll every POLL_TICKS ticks.
module snes_poll_sequencer
    import snes_pkg::*;
#(
    parameter int HALF_DIV   = 600,
    parameter int NUM_BITS   = 16,
    parameter int POLL_TICKS = 2778
) (
    input  logic                PCLK,
    input  logic                PRESET,
    input  logic                poll_start,
    input  logic                contRead,
    output logic                contWrite,
    output logic                contCLK,
    output logic [NUM_BITS-1:0] buttons,
    output logic                data_valid,
    output logic                busy
);
    localparam int BW = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;

    state_e              state_q, state_d;
    logic [1:0]          sync_q;
    logic [NUM_BITS-1:0] shift_q, buttons_q;
    logic [BW-1:0]       bit_q;
    logic [1:0]          tcnt_q;
    logic                dv_q, busy_q;
    logic                tick, auto_trig, accept, last_tick, sample, last_bit;

    ctrl_tick_gen #(.HALF_DIV(HALF_DIV)) u_tick (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .clr    (state_q == IDLE),
        .tick   (tick)
    );

`ifdef SNES_AUTOPOLL_EN
    localparam int PW = (POLL_TICKS > 1) ? $clog2(POLL_TICKS) : 1;

    logic          ftick;
    logic [PW-1:0] timer_q;

    // Separate free-running tick so the poll period is independent of the FSM.
    ctrl_tick_gen #(.HALF_DIV(HALF_DIV)) u_poll_tick (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .clr    (1'b0),
        .tick   (ftick)
    );

    assign auto_trig = ftick && (timer_q == PW'(POLL_TICKS - 1));

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET)         timer_q <= '0;
        else if (auto_trig) timer_q <= '0;
        else if (ftick)     timer_q <= timer_q + PW'(1);
    end
`else
    localparam int unused_poll_ticks = POLL_TICKS;
    assign auto_trig = 1'b0;
`endif

    assign accept    = (state_q == IDLE) && !busy_q && (poll_start || auto_trig);
    assign last_bit  = (bit_q == BW'(NUM_BITS - 1));
    assign last_tick = tick && (((state_q == LATCH) && (tcnt_q == 2'(LATCH_TICKS - 1))) ||
                                ((state_q == GAP)   && (tcnt_q == 2'(GAP_TICKS - 1)))   ||
                                (state_q == CLK_LO) || (state_q == CLK_HI));
    assign sample    = last_tick && ((state_q == GAP) || (state_q == CLK_HI));

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (accept)    state_d = LATCH;
            LATCH:  if (last_tick) state_d = GAP;
            GAP:    if (last_tick) state_d = last_bit ? DONE : CLK_LO;
            CLK_LO: if (last_tick) state_d = CLK_HI;
            CLK_HI: if (last_tick) state_d = last_bit ? DONE : CLK_LO;
            DONE:                  state_d = IDLE;
            default:               state_d = IDLE;
        endcase
    end

    always_comb begin
        contWrite = (state_q == LATCH);
        contCLK   = (state_q != CLK_LO);
    end

    // Bits land at shift[bit_q]; bit_q starts at 0 for the post-latch sample and saturates.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            sync_q    <= 2'b11;
            shift_q   <= '1;
            buttons_q <= '0;
            bit_q     <= '0;
            tcnt_q    <= '0;
            dv_q      <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], contRead};
            dv_q   <= (state_q == DONE);
            if (state_d != state_q) tcnt_q <= '0;
            else if (tick)          tcnt_q <= tcnt_q + 2'd1;
            if (accept) begin
                busy_q  <= 1'b1;
                shift_q <= '1;
                bit_q   <= '0;
            end else if (dv_q) begin
                busy_q  <= 1'b0;
            end
            if (sample) begin
                shift_q[bit_q] <= sync_q[1];
                if (!last_bit) bit_q <= bit_q + BW'(1);
            end
            if (state_q == DONE) buttons_q <= ~shift_q;
        end
    end

    assign buttons    = buttons_q;
    assign data_valid = dv_q;
    assign busy       = busy_q;

endmodule
